// File: rtl/rwt_axil2up_pkg.sv
// rtl/rwt_axil2up_pkg.sv - shared types and constants for the AXI4-Lite to uP bridge
//
// Purpose: channel FSM state encoding, AXI response codes and the data word
//          returned on a read that timed out.
// Ports:   none (package).

package rwt_axil2up_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_DEAD;

endpackage

// File: rtl/rwt_axil2up_chan.sv
// rtl/rwt_axil2up_chan.sv - one request/ack channel: IDLE -> REQ -> WAIT -> RESP
//
// Purpose: issues a one-cycle request, waits for an ack or a timeout, then
//          presents an AXI-style response until the master accepts it.
//          Instantiated once for writes and once for reads.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            accept a new transaction (only honoured in IDLE)
//   addr_in, data_in word address and request data sampled on start
//   ack, ack_data    slave acknowledge and its data (read channel only)
//   resp_ready       AXI B/R ready
//   req              one-cycle request pulse
//   addr             request word address, held until the next start
//   data             write channel: request data; read channel: response data
//   resp_valid, resp AXI B/R valid and response code
//   idle             channel is in IDLE

module rwt_axil2up_chan
  import rwt_axil2up_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 14,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter bit CAPTURE_ACK_DATA = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] addr_in,
  input  logic [31:0]              data_in,
  input  logic                     ack,
  input  logic [31:0]              ack_data,
  input  logic                     resp_ready,
  output logic                     req,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [31:0]              data,
  output logic                     resp_valid,
  output logic [1:0]               resp,
  output logic                     idle
);

  // Counter wide enough to hold TIMEOUT_CYCLES-1; at least one bit.
  localparam int CW   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TLIM_C = CW'(TLIM);

  state_t                    state_q, state_d;
  logic                      req_q, req_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [31:0]               data_q, data_d;
  logic                      valid_q, valid_d;
  logic [1:0]                resp_q, resp_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          addr_d  = addr_in;
          if (!CAPTURE_ACK_DATA) data_d = data_in;
        end
      end
      ST_REQ: begin
        // An ack in the request cycle itself is not a valid response.
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (ack) begin
          state_d = ST_RESP;
          valid_d = 1'b1;
          resp_d  = RESP_OKAY;
          if (CAPTURE_ACK_DATA) data_d = ack_data;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TLIM_C)) begin
          state_d = ST_RESP;
          valid_d = 1'b1;
          resp_d  = RESP_SLVERR;
          if (CAPTURE_ACK_DATA) data_d = TIMEOUT_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      resp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req        = req_q;
  assign addr       = addr_q;
  assign data       = data_q;
  assign resp_valid = valid_q;
  assign resp       = resp_q;
  assign idle       = (state_q == ST_IDLE);

endmodule

// File: rtl/rwt_axil2up.sv
// rtl/rwt_axil2up.sv - AXI4-Lite slave to simple req/ack microprocessor bus bridge
//
// Purpose: accepts AXI4-Lite reads and writes (full 32-bit words, no strobes)
//          and turns each into a one-cycle up_wreq/up_rreq, waiting for the
//          matching ack or a timeout. Write and read paths run independently.
// Ports:
//   up_clk, up_rst                          clock, asynchronous active-high reset
//   s_axi_aw*, s_axi_w*, s_axi_b*           AXI4-Lite write channels
//   s_axi_ar*, s_axi_r*                     AXI4-Lite read channels
//   up_wreq, up_waddr, up_wdata, up_wack    uP write request/ack
//   up_rreq, up_raddr, up_rdata, up_rack    uP read request/ack

module rwt_axil2up
  import rwt_axil2up_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 14,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     up_clk,
  input  logic                     up_rst,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [ADDRESS_WIDTH+1:0] s_axi_awaddr,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  input  logic [31:0]              s_axi_wdata,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  output logic [1:0]               s_axi_bresp,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  input  logic [ADDRESS_WIDTH+1:0] s_axi_araddr,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     up_wreq,
  output logic [ADDRESS_WIDTH-1:0] up_waddr,
  output logic [31:0]              up_wdata,
  input  logic                     up_wack,
  output logic                     up_rreq,
  output logic [ADDRESS_WIDTH-1:0] up_raddr,
  input  logic [31:0]              up_rdata,
  input  logic                     up_rack
);

  localparam int AW = ADDRESS_WIDTH;

  logic          w_idle, r_idle;
  logic          aw_fire, w_fire, ar_fire;
  logic          w_start, r_start;
  logic          aw_held_q, aw_held_d;
  logic          w_held_q, w_held_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          arready_q, arready_d;

  // Byte-lane bits are meaningless for full-word access.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  always_comb begin
    aw_fire = s_axi_awvalid & awready_q;
    w_fire  = s_axi_wvalid & wready_q;
    ar_fire = s_axi_arvalid & arready_q;

    aw_held_d = aw_held_q | aw_fire;
    w_held_d  = w_held_q | w_fire;
    awaddr_d  = aw_fire ? s_axi_awaddr[AW+1:2] : awaddr_q;
    wdata_d   = w_fire ? s_axi_wdata : wdata_q;

    // Start as soon as both beats are present, including the beat arriving
    // this cycle, so a same-cycle AW+W costs no extra latency.
    w_start = w_idle & aw_held_d & w_held_d;
    if (w_start) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end

    r_start = r_idle & ar_fire;

    // Readies are registered: they drop on the edge that starts a transaction
    // and come back one cycle after the channel returns to IDLE.
    awready_d = w_idle & ~w_start & ~aw_held_d;
    wready_d  = w_idle & ~w_start & ~w_held_d;
    arready_d = r_idle & ~r_start;
  end

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;

  rwt_axil2up_chan #(
    .ADDRESS_WIDTH   (AW),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
    .CAPTURE_ACK_DATA(1'b0)
  ) u_wchan (
    .clk       (up_clk),
    .rst       (up_rst),
    .start     (w_start),
    .addr_in   (awaddr_d),
    .data_in   (wdata_d),
    .ack       (up_wack),
    .ack_data  (32'h0),
    .resp_ready(s_axi_bready),
    .req       (up_wreq),
    .addr      (up_waddr),
    .data      (up_wdata),
    .resp_valid(s_axi_bvalid),
    .resp      (s_axi_bresp),
    .idle      (w_idle)
  );

  rwt_axil2up_chan #(
    .ADDRESS_WIDTH   (AW),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
    .CAPTURE_ACK_DATA(1'b1)
  ) u_rchan (
    .clk       (up_clk),
    .rst       (up_rst),
    .start     (r_start),
    .addr_in   (s_axi_araddr[AW+1:2]),
    .data_in   (32'h0),
    .ack       (up_rack),
    .ack_data  (up_rdata),
    .resp_ready(s_axi_rready),
    .req       (up_rreq),
    .addr      (up_raddr),
    .data      (s_axi_rdata),
    .resp_valid(s_axi_rvalid),
    .resp      (s_axi_rresp),
    .idle      (r_idle)
  );

endmodule

// File: tb/tb_rwt_axil2up.sv
// tb/tb_rwt_axil2up.sv - scoreboard bench for the AXI4-Lite to uP bridge

module tb_rwt_axil2up;

  localparam int AW = 14;
  localparam int TO = 16;

  logic          up_clk = 1'b0;
  logic          up_rst = 1'b1;
  logic          s_axi_awvalid = 1'b0;
  logic          s_axi_awready;
  logic [AW+1:0] s_axi_awaddr = '0;
  logic          s_axi_wvalid = 1'b0;
  logic          s_axi_wready;
  logic [31:0]   s_axi_wdata = '0;
  logic          s_axi_bvalid;
  logic          s_axi_bready = 1'b0;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_arvalid = 1'b0;
  logic          s_axi_arready;
  logic [AW+1:0] s_axi_araddr = '0;
  logic          s_axi_rvalid;
  logic          s_axi_rready = 1'b0;
  logic [31:0]   s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          up_wreq;
  logic [AW-1:0] up_waddr;
  logic [31:0]   up_wdata;
  logic          up_wack = 1'b0;
  logic          up_rreq;
  logic [AW-1:0] up_raddr;
  logic [31:0]   up_rdata = '0;
  logic          up_rack = 1'b0;

  int total = 0;
  int bad = 0;

  logic [45:0] exp_wq[$];
  logic [13:0] exp_rq[$];
  logic [1:0]  exp_bq[$];
  logic [33:0] exp_rdq[$];
  logic [45:0] mon_w;
  logic [13:0] mon_r;

  rwt_axil2up #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .up_clk(up_clk), .up_rst(up_rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
  );

  always #5 up_clk = ~up_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge up_clk);
    #1;
  endtask

  // Request monitor: every uP request pulse must match the next expected one.
  always @(posedge up_clk) begin
    #1;
    if (up_wreq === 1'b1) begin
      chk("wreq_expected", 32'(exp_wq.size() != 0), 32'd1);
      if (exp_wq.size() != 0) begin
        mon_w = exp_wq.pop_front();
        chk("waddr", 32'(up_waddr), 32'(mon_w[45:32]));
        chk("wdata", up_wdata, mon_w[31:0]);
      end
    end
    if (up_rreq === 1'b1) begin
      chk("rreq_expected", 32'(exp_rq.size() != 0), 32'd1);
      if (exp_rq.size() != 0) begin
        mon_r = exp_rq.pop_front();
        chk("raddr", 32'(up_raddr), 32'(mon_r));
      end
    end
  end

  task automatic push_write(input logic [15:0] addr, input logic [31:0] data, input logic [1:0] resp);
    exp_wq.push_back({addr[15:2], data});
    exp_bq.push_back(resp);
  endtask

  task automatic push_read(input logic [15:0] addr, input logic [1:0] resp, input logic [31:0] data);
    exp_rq.push_back(addr[15:2]);
    exp_rdq.push_back({resp, data});
  endtask

  task automatic handshake();
    int n = 0;
    logic aw_hs, w_hs, ar_hs;
    while ((s_axi_awvalid || s_axi_wvalid || s_axi_arvalid) && n < 40) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      ar_hs = s_axi_arvalid && s_axi_arready;
      step();
      n++;
      if (aw_hs) s_axi_awvalid = 1'b0;
      if (w_hs)  s_axi_wvalid = 1'b0;
      if (ar_hs) s_axi_arvalid = 1'b0;
    end
    chk("handshake_done", 32'(n < 40), 32'd1);
  endtask

  task automatic wait_wreq();
    int n = 0;
    while (up_wreq !== 1'b1 && n < 20) begin step(); n++; end
    chk("wreq_seen", 32'(up_wreq), 32'd1);
  endtask

  task automatic wait_rreq();
    int n = 0;
    while (up_rreq !== 1'b1 && n < 20) begin step(); n++; end
    chk("rreq_seen", 32'(up_rreq), 32'd1);
  endtask

  task automatic pulse_wack(input int delay);
    repeat (delay) step();
    up_wack = 1'b1;
    step();
    up_wack = 1'b0;
  endtask

  task automatic pulse_rack(input int delay, input logic [31:0] d);
    repeat (delay) step();
    up_rack = 1'b1;
    up_rdata = d;
    step();
    up_rack = 1'b0;
    up_rdata = 32'h0;
  endtask

  task automatic collect_b();
    int n = 0;
    logic [1:0] e;
    while (s_axi_bvalid !== 1'b1 && n < 100) begin step(); n++; end
    chk("bvalid_seen", 32'(s_axi_bvalid), 32'd1);
    e = exp_bq.pop_front();
    chk("bresp", 32'(s_axi_bresp), 32'(e));
    s_axi_bready = 1'b1;
    step();
    s_axi_bready = 1'b0;
    chk("bvalid_clear", 32'(s_axi_bvalid), 32'd0);
  endtask

  task automatic collect_r(input int hold);
    int n = 0;
    logic [33:0] e;
    while (s_axi_rvalid !== 1'b1 && n < 100) begin step(); n++; end
    chk("rvalid_seen", 32'(s_axi_rvalid), 32'd1);
    e = exp_rdq.pop_front();
    chk("rresp", 32'(s_axi_rresp), 32'(e[33:32]));
    chk("rdata", s_axi_rdata, e[31:0]);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("rvalid_hold", 32'(s_axi_rvalid), 32'd1);
      chk("rdata_hold", s_axi_rdata, e[31:0]);
    end
    s_axi_rready = 1'b1;
    step();
    s_axi_rready = 1'b0;
    chk("rvalid_clear", 32'(s_axi_rvalid), 32'd0);
  endtask

  initial begin
    int n;

    // Reset state
    step();
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_wready", 32'(s_axi_wready), 32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_wreq", 32'(up_wreq), 32'd0);
    chk("rst_waddr", 32'(up_waddr), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    up_rst = 1'b0;
    step();
    chk("post_rst_awready", 32'(s_axi_awready), 32'd1);
    chk("post_rst_wready", 32'(s_axi_wready), 32'd1);
    chk("post_rst_arready", 32'(s_axi_arready), 32'd1);

    // AW and W in the same cycle, ack three cycles after the request
    push_write(16'h0010, 32'hA5A5_0001, 2'b00);
    s_axi_awaddr = 16'h0010; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hA5A5_0001; s_axi_wvalid = 1'b1;
    handshake();
    wait_wreq();
    repeat (3) step();
    chk("bvalid_before_ack", 32'(s_axi_bvalid), 32'd0);
    pulse_wack(0);
    collect_b();

    // W one cycle ahead of AW
    push_write(16'h0008, 32'h0000_BEEF, 2'b00);
    s_axi_wdata = 32'h0000_BEEF; s_axi_wvalid = 1'b1;
    handshake();
    chk("wready_after_w", 32'(s_axi_wready), 32'd0);
    chk("awready_after_w", 32'(s_axi_awready), 32'd1);
    s_axi_awaddr = 16'h0008; s_axi_awvalid = 1'b1;
    handshake();
    wait_wreq();
    pulse_wack(1);
    collect_b();
    repeat (3) step();

    // Read with ack data, master stalls rready for five cycles
    push_read(16'h0004, 2'b00, 32'h1234_5678);
    s_axi_araddr = 16'h0004; s_axi_arvalid = 1'b1;
    chk("arready_idle", 32'(s_axi_arready), 32'd1);
    handshake();
    chk("arready_busy", 32'(s_axi_arready), 32'd0);
    wait_rreq();
    pulse_rack(2, 32'h1234_5678);
    collect_r(5);

    // Read timeout, then late acks are ignored
    push_read(16'h0020, 2'b10, 32'hDEAD_DEAD);
    s_axi_araddr = 16'h0020; s_axi_arvalid = 1'b1;
    handshake();
    wait_rreq();
    n = 0;
    while (s_axi_rvalid !== 1'b1 && n < 40) begin step(); n++; end
    chk("timeout_latency", 32'(n), 32'd17);
    up_rack = 1'b1; up_rdata = 32'h1111_1111;
    step();
    up_rack = 1'b0; up_rdata = 32'h0;
    chk("late_rack_rvalid", 32'(s_axi_rvalid), 32'd1);
    chk("late_rack_rdata", s_axi_rdata, 32'hDEAD_DEAD);
    collect_r(0);
    pulse_rack(0, 32'h2222_2222);
    chk("idle_rack_rvalid", 32'(s_axi_rvalid), 32'd0);
    step();

    // Next read completes normally; low address bits ignored
    push_read(16'h0103, 2'b00, 32'hCAFE_F00D);
    s_axi_araddr = 16'h0103; s_axi_arvalid = 1'b1;
    handshake();
    wait_rreq();
    pulse_rack(1, 32'hCAFE_F00D);
    collect_r(0);

    // Write timeout
    push_write(16'h0100, 32'h0000_0042, 2'b10);
    s_axi_awaddr = 16'h0100; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0000_0042; s_axi_wvalid = 1'b1;
    handshake();
    collect_b();
    step();

    // Concurrent write and read, read acked first
    push_write(16'h3FFC, 32'h0F0F_F0F0, 2'b00);
    push_read(16'hFFFF, 2'b00, 32'h8765_4321);
    s_axi_awaddr = 16'h3FFC; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0F0F_F0F0; s_axi_wvalid = 1'b1;
    s_axi_araddr = 16'hFFFF; s_axi_arvalid = 1'b1;
    handshake();
    wait_wreq();
    chk("concurrent_rreq", 32'(up_rreq), 32'd1);
    pulse_rack(2, 32'h8765_4321);
    chk("concurrent_bvalid_pending", 32'(s_axi_bvalid), 32'd0);
    pulse_wack(2);
    collect_r(0);
    collect_b();
    step();

    // Reset during write WAIT discards the transaction
    push_write(16'h0200, 32'h5555_AAAA, 2'b00);
    s_axi_awaddr = 16'h0200; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h5555_AAAA; s_axi_wvalid = 1'b1;
    handshake();
    wait_wreq();
    step();
    step();
    up_rst = 1'b1;
    #1;
    void'(exp_bq.pop_back());
    chk("mid_rst_wreq", 32'(up_wreq), 32'd0);
    chk("mid_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("mid_rst_awready", 32'(s_axi_awready), 32'd0);
    chk("mid_rst_waddr", 32'(up_waddr), 32'd0);
    step();
    up_rst = 1'b0;
    step();
    chk("rerst_awready", 32'(s_axi_awready), 32'd1);
    chk("rerst_arready", 32'(s_axi_arready), 32'd1);
    pulse_wack(0);
    chk("stale_wack_bvalid", 32'(s_axi_bvalid), 32'd0);

    push_write(16'h0040, 32'h7777_0000, 2'b00);
    s_axi_awaddr = 16'h0040; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h7777_0000; s_axi_wvalid = 1'b1;
    handshake();
    wait_wreq();
    pulse_wack(1);
    collect_b();

    repeat (4) step();
    chk("w_sb_empty", 32'(exp_wq.size()), 32'd0);
    chk("r_sb_empty", 32'(exp_rq.size()), 32'd0);
    chk("b_sb_empty", 32'(exp_bq.size()), 32'd0);
    chk("rd_sb_empty", 32'(exp_rdq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rwt_axil2up.md
RWT_AXIL2UP -- requirements
Module: rwt_axil2up
Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 14, width of up_waddr/up_raddr (word addresses).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles to wait for an ack; 0 disables the timeout.
REQ-003 SHALL have port up_clk  in  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port up_rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_axi_awvalid  in  1  AXI4-Lite write address valid.
REQ-006 SHALL have port s_axi_awready  out  1  write address ready.
REQ-007 SHALL have port s_axi_awaddr  in  ADDRESS_WIDTH+2  byte address.
REQ-008 SHALL have port s_axi_wvalid  in  1  write data valid.
REQ-009 SHALL have port s_axi_wready  out  1  write data ready.
REQ-010 SHALL have port s_axi_wdata  in  32  write data; no WSTRB port; every write is a full word.
REQ-011 SHALL have port s_axi_bvalid  out  1  write response valid.
REQ-012 SHALL have port s_axi_bready  in  1  write response ready.
REQ-013 SHALL have port s_axi_bresp  out  2  00 OKAY, 10 SLVERR.
REQ-014 SHALL have port s_axi_arvalid  in  1  read address valid.
REQ-015 SHALL have port s_axi_arready  out  1  read address ready.
REQ-016 SHALL have port s_axi_araddr  in  ADDRESS_WIDTH+2  byte address.
REQ-017 SHALL have port s_axi_rvalid  out  1  read data valid.
REQ-018 SHALL have port s_axi_rready  in  1  read data ready.
REQ-019 SHALL have port s_axi_rdata  out  32  read data.
REQ-020 SHALL have port s_axi_rresp  out  2  00 OKAY, 10 SLVERR.
REQ-021 SHALL have port up_wreq  out  1  one-cycle write request pulse.
REQ-022 SHALL have port up_waddr  out  ADDRESS_WIDTH  write word address.
REQ-023 SHALL have port up_wdata  out  32  write data.
REQ-024 SHALL have port up_wack  in  1  write acknowledge.
REQ-025 SHALL have port up_rreq  out  1  one-cycle read request pulse.
REQ-026 SHALL have port up_raddr  out  ADDRESS_WIDTH  read word address.
REQ-027 SHALL have port up_rdata  in  32  read data, valid in the up_rack cycle.
REQ-028 SHALL have port up_rack  in  1  read acknowledge.
Function
REQ-029 SHALL run independent write and read FSMs, each IDLE -> REQ -> WAIT -> RESP -> IDLE; both may be in flight at the same time.
REQ-030 Write IDLE SHALL hold awready/wready high until its beat is captured; AW and W SHALL be accepted in any order or the same cycle; both must be held before REQ.
REQ-031 In REQ, up_wreq/up_rreq SHALL be high for exactly one cycle, with up_waddr = awaddr[ADDRESS_WIDTH+1:2] (likewise raddr); addr/data SHALL stay stable until the next request.
REQ-032 WAIT SHALL end on the first cycle with ack high (earliest one cycle after req), giving resp OKAY; for reads, rdata SHALL capture up_rdata in that cycle.
REQ-033 WAIT SHALL end after TIMEOUT_CYCLES cycles without ack, giving SLVERR, with rdata = 32'hDEAD_DEAD for reads.
REQ-034 RESP SHALL hold bvalid/rvalid and data stable until the ready handshake, then return to IDLE; arready SHALL be high only in read IDLE.
REQ-035 up_wack/up_rack outside WAIT, including late acks after a timeout, SHALL be ignored.
REQ-036 Address bits [1:0] SHALL be ignored.
Reset
REQ-037 On up_rst, asynchronously: both FSMs go to IDLE; up_wreq, up_rreq, bvalid, rvalid, awready, wready and arready are 0; addr/data/resp outputs and the timeout counters are 0.
REQ-038 A reset mid-transaction SHALL discard it with no response; the ready outputs SHALL rise on the first clock edge after up_rst falls.
Structure
REQ-039 A shared package rwt_axil2up_pkg SHALL hold the FSM state enum, the RESP_OKAY/RESP_SLVERR constants and the TIMEOUT_DATA constant 32'hDEAD_DEAD.
REQ-040 The sub-module rwt_axil2up_chan SHALL implement the REQ/WAIT/timeout sequencing and be instantiated once for writes and once for reads.
Verification
REQ-041 AW 0x0010 and W 0xA5A5_0001 in the same cycle, slave acks 3 cycles later -> single up_wreq pulse with waddr 0x004, then bresp 00.
REQ-042 W one cycle before AW 0x0008 -> one write to waddr 0x002, no duplicate pulse.
REQ-043 Read 0x0004, slave returns 0x1234_5678 with rack -> rdata 0x1234_5678, rresp 00; hold rready low for 5 cycles -> rvalid and rdata stable.
REQ-044 TIMEOUT_CYCLES=16, no rack -> rresp 10 and rdata 0xDEAD_DEAD after 16 cycles; a late rack is ignored and the next read completes OKAY.
REQ-045 Write and read issued concurrently with out-of-order acks -> both complete with correct data and resp.
REQ-046 up_rst asserted during write WAIT -> up_wreq 0 and bvalid 0 immediately; the next write completes normally.
